// File: rtl/ascon_rng.sv
// ascon_rng: bank of LFSR lanes producing fresh mask randomness for a
// masked Ascon core. Lanes are loaded word by word in SEED, optionally
// free-run for WARMUP steps in WARM, then stream one word per handshake
// in RUN. The optional lane health monitor is compiled in by defining
// ASCON_RNG_HEALTH_EN; without it err_o is tied low and there is no ERR state.
module ascon_rng #(
    parameter int D = 2,
    parameter int PAR = 22,
    parameter int COL_SIZE = 5,
    parameter int LFSR_WIDTH = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001,
    parameter int LFSR_CONFIG = 0,
    parameter int WARMUP = 32,
    localparam int RAND_WIDTH = D*COL_SIZE*PAR + (D+1)*D/2*PAR,
    localparam int NUM_LFSR = (RAND_WIDTH + LFSR_WIDTH - 1) / LFSR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_valid_i,
    input  logic [LFSR_WIDTH-1:0] seed_i,
    output logic                  seed_ready_o,
    input  logic                  reseed_i,
    output logic                  rnd_valid_o,
    input  logic                  rnd_ready_i,
    output logic [RAND_WIDTH-1:0] rnd_o,
    output logic [15:0]           rnd_cnt_o,
    output logic                  err_o
);

    localparam int IDX_W  = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LFSR - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = (WARMUP > 0) ? WARM_W'(WARMUP - 1) : '0;

`ifdef ASCON_RNG_HEALTH_EN
    typedef enum logic [1:0] {ST_SEED, ST_WARM, ST_RUN, ST_ERR} state_t;
`else
    typedef enum logic [1:0] {ST_SEED, ST_WARM, ST_RUN} state_t;
`endif

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [WARM_W-1:0]       warm_cnt;
    logic [15:0]             rnd_cnt;
    logic                    rnd_valid;
    logic [LFSR_WIDTH-1:0]   lane      [NUM_LFSR];
    logic [LFSR_WIDTH-1:0]   lane_next [NUM_LFSR];
    logic [NUM_LFSR*LFSR_WIDTH-1:0] lane_flat;

    // One LFSR step in the configured structure (0 Fibonacci, 1 Galois).
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        if (LFSR_CONFIG == 1)
            return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
        else
            return {s[LFSR_WIDTH-2:0], ^(s & LFSR_POLY)};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LFSR; gi++) begin : g_lane
            assign lane_next[gi] = lfsr_step(lane[gi]);
            assign lane_flat[gi*LFSR_WIDTH +: LFSR_WIDTH] = lane[gi];
        end
    endgenerate

    // Lane 0 sits in the least significant bits; surplus top bits are dropped.
    assign rnd_o        = lane_flat[RAND_WIDTH-1:0];
    assign rnd_cnt_o    = rnd_cnt;
    assign rnd_valid_o  = rnd_valid;
    assign seed_ready_o = (state == ST_SEED);

`ifdef ASCON_RNG_HEALTH_EN
    logic [NUM_LFSR-1:0] lane_zero;
    logic                err;
    logic                any_zero;

    generate
        for (gi = 0; gi < NUM_LFSR; gi++) begin : g_health
            assign lane_zero[gi] = (lane[gi] == '0);
        end
    endgenerate

    assign any_zero = |lane_zero;
    assign err_o    = err;
`else
    assign err_o = 1'b0;
`endif

    // Sequencer: seeding, warm-up, streaming and (optionally) health lock-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEED;
            idx       <= '0;
            warm_cnt  <= '0;
            rnd_cnt   <= '0;
            rnd_valid <= 1'b0;
            for (int i = 0; i < NUM_LFSR; i++) lane[i] <= '0;
`ifdef ASCON_RNG_HEALTH_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_SEED: begin
                    if (seed_valid_i) begin
                        // An all-zero word would lock the lane, so load 1 instead.
                        lane[idx] <= (seed_i == '0) ? LFSR_WIDTH'(1) : seed_i;
                        if (idx == IDX_LAST) begin
                            idx      <= '0;
                            rnd_cnt  <= '0;
                            warm_cnt <= '0;
                            if (WARMUP == 0) begin
                                state     <= ST_RUN;
                                rnd_valid <= 1'b1;
                            end else begin
                                state <= ST_WARM;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_WARM: begin
                    for (int i = 0; i < NUM_LFSR; i++) lane[i] <= lane_next[i];
                    warm_cnt <= warm_cnt + 1'b1;
                    if (warm_cnt == WARM_LAST) begin
                        state     <= ST_RUN;
                        rnd_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rnd_ready_i) begin
                        for (int i = 0; i < NUM_LFSR; i++) lane[i] <= lane_next[i];
                        rnd_cnt <= rnd_cnt + 16'd1;
                    end
                    // A transfer in the reseed cycle still completes above.
                    if (reseed_i) begin
                        state     <= ST_SEED;
                        rnd_valid <= 1'b0;
                        idx       <= '0;
                    end
                end
`ifdef ASCON_RNG_HEALTH_EN
                ST_ERR: begin
                    rnd_valid <= 1'b0;
                end
`endif
                default: begin
                    state     <= ST_SEED;
                    rnd_valid <= 1'b0;
                end
            endcase
`ifdef ASCON_RNG_HEALTH_EN
            // A stuck-at-zero lane is fatal: latch the error until reset.
            if ((state == ST_WARM || state == ST_RUN) && any_zero) begin
                state     <= ST_ERR;
                err       <= 1'b1;
                rnd_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ascon_rng.sv
// tb_ascon_rng: three instances (Fibonacci with warm-up, Galois and
// Fibonacci without warm-up) checked against a behavioural model through
// a scoreboard queue, plus hand-written corner-case sequences.
module tb_ascon_rng;
    localparam int W  = 31;
    localparam int NL = 10;
    localparam int RW = 286;
    localparam int NI = 3;
    localparam logic [W-1:0] POLY = 31'h10000001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sv   [NI];
    logic [W-1:0]  sd   [NI];
    logic          rdy  [NI];
    logic          rs   [NI];
    logic          srdy [NI];
    logic          vld  [NI];
    logic [RW-1:0] rnd  [NI];
    logic [15:0]   cnt  [NI];
    logic          err  [NI];

    always #5 clk = ~clk;

    ascon_rng u_fib_warm (
        .clk(clk), .rst_n(rst_n), .seed_valid_i(sv[0]), .seed_i(sd[0]),
        .seed_ready_o(srdy[0]), .reseed_i(rs[0]), .rnd_valid_o(vld[0]),
        .rnd_ready_i(rdy[0]), .rnd_o(rnd[0]), .rnd_cnt_o(cnt[0]), .err_o(err[0])
    );

    ascon_rng #(.LFSR_CONFIG(1), .WARMUP(0)) u_gal (
        .clk(clk), .rst_n(rst_n), .seed_valid_i(sv[1]), .seed_i(sd[1]),
        .seed_ready_o(srdy[1]), .reseed_i(rs[1]), .rnd_valid_o(vld[1]),
        .rnd_ready_i(rdy[1]), .rnd_o(rnd[1]), .rnd_cnt_o(cnt[1]), .err_o(err[1])
    );

    ascon_rng #(.LFSR_CONFIG(0), .WARMUP(0)) u_fib (
        .clk(clk), .rst_n(rst_n), .seed_valid_i(sv[2]), .seed_i(sd[2]),
        .seed_ready_o(srdy[2]), .reseed_i(rs[2]), .rnd_valid_o(vld[2]),
        .rnd_ready_i(rdy[2]), .rnd_o(rnd[2]), .rnd_cnt_o(cnt[2]), .err_o(err[2])
    );

    // Behavioural model state per instance (state: 0 SEED, 1 WARM, 2 RUN).
    int           m_cfg   [NI];
    int           m_wu    [NI];
    int           m_state [NI];
    int           m_idx   [NI];
    int           m_warm  [NI];
    logic [15:0]  m_cnt   [NI];
    logic [W-1:0] m_lane  [NI][NL];

    typedef struct {
        int            k;
        logic [RW-1:0] rnd;
        logic [15:0]   cnt;
        logic          vld;
        logic          srdy;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic rdy;
        logic rs;
        logic sv;
        logic exp_vld;
        logic exp_srdy;
    } op_t;
    op_t ops[10];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    function automatic logic [W-1:0] m_next(input logic [W-1:0] s, input int c);
        logic [W-1:0] r;
        if (c == 1) begin
            r = s >> 1;
            if (s[0]) r = r ^ POLY;
        end else begin
            r = {s[W-2:0], ^(s & POLY)};
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] m_rnd(input int k);
        logic [NL*W-1:0] f;
        for (int i = 0; i < NL; i++) f[i*W +: W] = m_lane[k][i];
        return f[RW-1:0];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NI; k++) begin
            m_state[k] = 0;
            m_idx[k]   = 0;
            m_warm[k]  = 0;
            m_cnt[k]   = 16'd0;
            for (int i = 0; i < NL; i++) m_lane[k][i] = '0;
        end
    endtask

    task automatic m_advance(input int k, input logic v, input logic [W-1:0] d,
                             input logic r, input logic s);
        case (m_state[k])
            0: if (v) begin
                m_lane[k][m_idx[k]] = (d == '0) ? 31'd1 : d;
                if (m_idx[k] == NL - 1) begin
                    m_idx[k]   = 0;
                    m_cnt[k]   = 16'd0;
                    m_warm[k]  = 0;
                    m_state[k] = (m_wu[k] == 0) ? 2 : 1;
                end else begin
                    m_idx[k]++;
                end
            end
            1: begin
                for (int i = 0; i < NL; i++) m_lane[k][i] = m_next(m_lane[k][i], m_cfg[k]);
                m_warm[k]++;
                if (m_warm[k] == m_wu[k]) m_state[k] = 2;
            end
            2: begin
                if (r) begin
                    for (int i = 0; i < NL; i++) m_lane[k][i] = m_next(m_lane[k][i], m_cfg[k]);
                    m_cnt[k] = m_cnt[k] + 16'd1;
                end
                if (s) m_state[k] = 0;
            end
            default: m_state[k] = 0;
        endcase
    endtask

    // One clock cycle on instance k: drive, predict, then compare after the edge.
    task automatic cyc(input int k, input logic v, input logic [W-1:0] d,
                       input logic r, input logic s);
        exp_t e;
        logic xfer;
        @(negedge clk);
        sv[k] = v; sd[k] = d; rdy[k] = r; rs[k] = s;
        xfer = (m_state[k] == 2) && r;
        m_advance(k, v, d, r, s);
        e.k = k; e.rnd = m_rnd(k); e.cnt = m_cnt[k];
        e.vld = (m_state[k] == 2); e.srdy = (m_state[k] == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        sv[k] = 1'b0; rdy[k] = 1'b0; rs[k] = 1'b0;
        e = sb.pop_front();
        chk("rnd_o", rnd[e.k], e.rnd);
        chk("rnd_cnt_o", {270'd0, cnt[e.k]}, {270'd0, e.cnt});
        chk("rnd_valid_o", {285'd0, vld[e.k]}, {285'd0, e.vld});
        chk("seed_ready_o", {285'd0, srdy[e.k]}, {285'd0, e.srdy});
        chk("err_o", {285'd0, err[e.k]}, '0);
        if (xfer) $display("xfer inst=%0d cnt=%0d lane0=%h", k, cnt[k], rnd[k][W-1:0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] held_rnd;
        logic [15:0]   held_cnt;
        logic [W-1:0]  w;

        m_cfg[0] = 0; m_wu[0] = 32;
        m_cfg[1] = 1; m_wu[1] = 0;
        m_cfg[2] = 0; m_wu[2] = 0;
        for (int k = 0; k < NI; k++) begin
            sv[k] = 1'b0; sd[k] = '0; rdy[k] = 1'b0; rs[k] = 1'b0;
        end
        m_reset();

        // RUN-phase table for the warm-up instance.
        ops[0] = '{rdy:1'b1, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[1] = '{rdy:1'b1, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[2] = '{rdy:1'b0, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[3] = '{rdy:1'b1, rs:1'b0, sv:1'b1, exp_vld:1'b1, exp_srdy:1'b0};
        ops[4] = '{rdy:1'b0, rs:1'b0, sv:1'b1, exp_vld:1'b1, exp_srdy:1'b0};
        ops[5] = '{rdy:1'b1, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[6] = '{rdy:1'b1, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[7] = '{rdy:1'b0, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[8] = '{rdy:1'b1, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};
        ops[9] = '{rdy:1'b1, rs:1'b0, sv:1'b0, exp_vld:1'b1, exp_srdy:1'b0};

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset rnd_o", rnd[k], '0);
            chk("reset rnd_cnt_o", {270'd0, cnt[k]}, '0);
            chk("reset rnd_valid_o", {285'd0, vld[k]}, '0);
            chk("reset err_o", {285'd0, err[k]}, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) chk("seed_ready after reset", {285'd0, srdy[k]}, 286'd1);

        // Instance 0: seeds 1..10 with an idle gap and an ignored reseed.
        for (int i = 0; i < NL; i++) begin
            if (i == 4) cyc(0, 1'b0, 31'h7FFF_FFFF, 1'b0, 1'b1);
            cyc(0, 1'b1, W'(i + 1), 1'b0, 1'b0);
        end
        chk("seed_ready low after last accept", {285'd0, srdy[0]}, '0);
        // Warm-up: valid rises exactly on the 32nd edge after the accept.
        for (int i = 1; i <= 32; i++) begin
            cyc(0, 1'b0, '0, 1'b0, 1'b0);
            chk("warmup rnd_valid_o", {285'd0, vld[0]}, {285'd0, (i == 32)});
        end
        chk("rnd_cnt_o at RUN entry", {270'd0, cnt[0]}, '0);

        // Table-driven RUN operations.
        for (int i = 0; i < 10; i++) begin
            cyc(0, ops[i].sv, 31'h0, ops[i].rdy, ops[i].rs);
            chk("table rnd_valid_o", {285'd0, vld[0]}, {285'd0, ops[i].exp_vld});
            chk("table seed_ready_o", {285'd0, srdy[0]}, {285'd0, ops[i].exp_srdy});
        end

        // Stall for 5 cycles: output and count frozen.
        held_rnd = rnd[0];
        held_cnt = cnt[0];
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b0, '0, 1'b0, 1'b0);
            chk("stall rnd_o held", rnd[0], held_rnd);
            chk("stall rnd_cnt_o held", {270'd0, cnt[0]}, {270'd0, held_cnt});
        end
        // Reseed with a transfer in the same cycle.
        cyc(0, 1'b0, '0, 1'b1, 1'b1);
        chk("reseed transfer counted", {270'd0, cnt[0]}, {270'd0, held_cnt + 16'd1});
        chk("reseed rnd_valid_o", {285'd0, vld[0]}, '0);
        chk("reseed seed_ready_o", {285'd0, srdy[0]}, 286'd1);

        // Instance 1: Galois, no warm-up; lane0=1, lane3 zero seed.
        for (int i = 0; i < NL; i++) begin
            w = (i == 0) ? 31'd1 : (i == 3) ? 31'd0 : W'($urandom);
            cyc(1, 1'b1, w, 1'b0, 1'b0);
        end
        chk("galois valid at once", {285'd0, vld[1]}, 286'd1);
        chk("galois lane0 seed", {255'd0, rnd[1][W-1:0]}, 286'd1);
        chk("zero seed lane3", {255'd0, rnd[1][3*W +: W]}, 286'd1);
        cyc(1, 1'b0, '0, 1'b1, 1'b0);
        chk("galois lane0 step", {255'd0, rnd[1][W-1:0]}, 286'h10000001);
        for (int i = 0; i < 20; i++)
            cyc(1, 1'($urandom), W'($urandom), 1'($urandom), 1'b0);

        // Instance 2: Fibonacci, no warm-up; lane0=1.
        for (int i = 0; i < NL; i++) begin
            w = (i == 0) ? 31'd1 : W'($urandom);
            cyc(2, 1'b1, w, 1'b0, 1'b0);
        end
        chk("fib lane0 seed", {255'd0, rnd[2][W-1:0]}, 286'd1);
        cyc(2, 1'b0, '0, 1'b1, 1'b0);
        chk("fib lane0 step1", {255'd0, rnd[2][W-1:0]}, 286'd3);
        cyc(2, 1'b0, '0, 1'b1, 1'b0);
        chk("fib lane0 step2", {255'd0, rnd[2][W-1:0]}, 286'd7);
        for (int i = 0; i < 10; i++)
            cyc(2, 1'b0, '0, 1'($urandom), 1'b0);

        // Asynchronous reset mid-transfer: clears at once, no transfer lands.
        @(negedge clk);
        rdy[1] = 1'b1;
        rdy[2] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("async reset rnd_o", rnd[k], '0);
            chk("async reset rnd_valid_o", {285'd0, vld[k]}, '0);
            chk("async reset rnd_cnt_o", {270'd0, cnt[k]}, '0);
        end
        @(posedge clk);
        #1;
        chk("reset hold rnd_cnt_o", {270'd0, cnt[1]}, '0);
        chk("reset hold rnd_o", rnd[2], '0);
        @(negedge clk);
        rdy[1] = 1'b0;
        rdy[2] = 1'b0;
        rst_n = 1'b1;
        m_reset();
        for (int k = 0; k < NI; k++) cyc(k, 1'b0, '0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_rng.md
ASCON_RNG -- requirements
Module: ascon_rng

Interface
REQ-001 The parameter D SHALL default to 2 and set the masking order (shares = D+1).
REQ-002 The parameter PAR SHALL default to 22 and set the bits processed per round-slice.
REQ-003 The parameter COL_SIZE SHALL default to 5 and set the Ascon column size.
REQ-004 The parameter LFSR_WIDTH SHALL default to 31 and set the bits per lane.
REQ-005 The parameter LFSR_POLY SHALL default to 31'h10000001 and set the feedback taps.
REQ-006 The parameter LFSR_CONFIG SHALL default to 0 and select the lane structure: 0 Fibonacci, 1 Galois.
REQ-007 The parameter WARMUP SHALL default to 32 and set the number of free-run steps after seeding.
REQ-008 The derived constant RAND_WIDTH SHALL equal D*COL_SIZE*PAR + (D+1)*D/2*PAR (286 at defaults).
REQ-009 The derived constant NUM_LFSR SHALL equal ceil(RAND_WIDTH/LFSR_WIDTH) (10 at defaults).
REQ-010 Clock and reset SHALL be one clock and an asynchronous, active-low reset, on these ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-011 The remaining ports SHALL be:
- seed_valid_i  in  1  seed word offered.
- seed_i  in  LFSR_WIDTH  seed word.
- seed_ready_o  out  1  seed word accepted when high with seed_valid_i.
- reseed_i  in  1  request re-seeding (sampled in RUN only).
- rnd_valid_o  out  1  rnd_o valid.
- rnd_ready_i  in  1  consumer accepts rnd_o.
- rnd_o  out  RAND_WIDTH  mask randomness.
- rnd_cnt_o  out  16  transfers since entering RUN, wraps 0xFFFF->0.
- err_o  out  1  sticky health error (0 when the health feature is not compiled in).

Function
REQ-012 The FSM SHALL have states SEED, WARM, RUN (plus ERR, present only when the health feature is compiled in).
REQ-013 In SEED, seed_ready_o SHALL be 1, and each seed_valid_i&&seed_ready_o cycle SHALL load lane[idx] and increment idx.
REQ-014 A seed word of all-zeros SHALL be loaded as 1 (lockup avoidance).
REQ-015 Accepting the word for idx=NUM_LFSR-1 SHALL move the FSM to WARM (or to RUN directly if WARMUP=0), clear idx and clear rnd_cnt_o.
REQ-016 WARM SHALL advance all lanes once per cycle for exactly WARMUP cycles, then move to RUN.
REQ-017 A Fibonacci step SHALL compute state = {state[LFSR_WIDTH-2:0], ^(state & LFSR_POLY)}.
REQ-018 A Galois step SHALL compute state = (state >> 1) ^ (state[0] ? LFSR_POLY : 0).
REQ-019 rnd_o SHALL equal the concatenation {lane[NUM_LFSR-1],...,lane[0]} truncated to its low RAND_WIDTH bits.
REQ-020 rnd_valid_o SHALL be 1 only in RUN.
REQ-021 While rnd_valid_o && !rnd_ready_i, rnd_o SHALL be held stable.
REQ-022 Each rnd_valid_o&&rnd_ready_i cycle SHALL advance all lanes once and increment rnd_cnt_o; throughput SHALL be one word per cycle, and the output SHALL update on the next edge.
REQ-023 On reseed_i=1 in RUN the FSM SHALL move to SEED next cycle; a transfer in the same cycle SHALL complete and be counted.
REQ-024 seed_valid_i outside SEED SHALL be ignored, and reseed_i outside RUN SHALL be ignored.

Reset
REQ-025 While rst_n=0 and after reset, all registers SHALL clear: state=SEED, idx=0, lanes=0, rnd_valid_o=0, rnd_o=0, rnd_cnt_o=0, err_o=0.
REQ-026 After reset release, seed_ready_o SHALL be 1.
REQ-027 Reset asserted mid-operation (any state) SHALL abort immediately, with no partial transfer completing.

Configuration
REQ-028 When the macro ASCON_RNG_HEALTH_EN is defined, any lane equal to 0 in WARM or RUN SHALL set err_o=1 (sticky until reset), move the FSM to ERR, and force rnd_valid_o=0 and seed_ready_o=0.
REQ-029 When ASCON_RNG_HEALTH_EN is undefined, no check SHALL be performed, err_o SHALL be tied to 0, and ERR SHALL not exist.

Verification
REQ-030 Reset, then seed words 0x1..0xA with WARMUP=32 -> seed_ready_o low after the 10th accept, rnd_valid_o high 33 cycles after the 10th accept cycle, rnd_cnt_o=0.
REQ-031 Fibonacci, WARMUP=0, lane0 seed 0x00000001 -> lane0 slice of rnd_o = 0x00000001, and after one transfer = 0x00000003.
REQ-032 Galois, WARMUP=0, lane0 seed 0x00000001 -> after one transfer lane0 slice = 0x10000001.
REQ-033 Seed word 0x00000000 on lane 3 -> lane3 slice = 0x00000001 when WARMUP=0.
REQ-034 In RUN, hold rnd_ready_i=0 for 5 cycles -> rnd_o unchanged and rnd_cnt_o unchanged; then reseed_i=1 with rnd_ready_i=1 in one cycle -> rnd_cnt_o+1, next cycle rnd_valid_o=0 and seed_ready_o=1.
REQ-035 With ASCON_RNG_HEALTH_EN defined, force lane5=0 in RUN -> next cycle err_o=1 and rnd_valid_o=0, held until rst_n=0.
